// File: rtl/fft_pingpong_buffer.sv
// Double-buffered complex sample store for the FFT accelerator.
// CPU fills one bank while the accelerator owns the other; banks swap by pointer.
module fft_pingpong_buffer #(
   parameter int N_POINTS  = 32,
   parameter int WORDWIDTH = 16,
   parameter int ADDR_W    = $clog2(2*N_POINTS)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_en_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   input  logic                 commit_i,
   input  logic                 release_i,
   input  logic                 acc_we_i,
   input  logic [ADDR_W-1:0]    acc_addr_i,
   input  logic [WORDWIDTH-1:0] acc_data_i,
   input  logic                 acc_done_i,
   output logic [WORDWIDTH-1:0] data_o_r [N_POINTS],
   output logic [WORDWIDTH-1:0] data_o_i [N_POINTS],
   output logic                 frame_valid_o,
   output logic                 result_valid_o,
   output logic                 commit_err_o,
   output logic                 fill_sel_o
);

   localparam int NW = 2*N_POINTS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VALID  = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   fill_sel_q;
   logic   swap;
   logic   err_d;
   logic   commit_err_q;
   logic [31:0] cpu_data_q;

   logic                 region;
   logic [ADDR_W-1:0]    cpu_idx;
   logic                 cpu_wr;
   logic                 cpu_rd;
   logic                 acc_wr;
   logic [WORDWIDTH-1:0] rd_word;
   logic [WORDWIDTH-1:0] comp_w [NW];
   logic [WORDWIDTH-1:0] fill_w [NW];

   // Upper address/data bits are don't-care by definition.
   logic unused_bits;
   assign unused_bits = ^{cpu_addr_i, cpu_data_i};

   assign region  = cpu_addr_i[ADDR_W];
   assign cpu_idx = cpu_addr_i[ADDR_W-1:0];
   assign cpu_wr  = cpu_en_i & cpu_we_i & ~region;
   assign cpu_rd  = cpu_en_i & ~cpu_we_i;
   assign acc_wr  = acc_we_i & (state_q == VALID);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [WORDWIDTH-1:0] mem [NW];
      logic                 cpu_hit;
      logic                 acc_hit;
      logic [ADDR_W-1:0]    widx;
      logic [WORDWIDTH-1:0] wdata;

      assign cpu_hit = cpu_wr & (fill_sel_q == 1'(b));
      assign acc_hit = acc_wr & (fill_sel_q != 1'(b));
      assign widx    = cpu_hit ? cpu_idx : acc_addr_i;
      assign wdata   = cpu_hit ? cpu_data_i[WORDWIDTH-1:0] : acc_data_i;

      // Bank storage; only clocked when a write targets this bank.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < NW; i++) begin
               mem[i] <= '0;
            end
         end else if (cpu_hit | acc_hit) begin
            mem[widx] <= wdata;
         end
      end
   end

   // Steer the two physical banks onto their fill/compute roles.
   always_comb begin
      for (int i = 0; i < NW; i++) begin
         fill_w[i] = fill_sel_q ? g_bank[1].mem[i] : g_bank[0].mem[i];
         comp_w[i] = fill_sel_q ? g_bank[0].mem[i] : g_bank[1].mem[i];
      end
   end

   // Parallel real/imag view of the compute bank for the accelerator.
   always_comb begin
      for (int k = 0; k < N_POINTS; k++) begin
         data_o_r[k] = comp_w[k];
         data_o_i[k] = comp_w[k+N_POINTS];
      end
   end

   assign rd_word = region ? comp_w[cpu_idx] : fill_w[cpu_idx];

   // Registered CPU read, sign-extended; holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_data_q <= '0;
      end else if (cpu_rd) begin
         cpu_data_q <= 32'($signed(rd_word));
      end
   end

   // Ownership FSM state, bank pointer and commit error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fill_sel_q   <= 1'b0;
         commit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         commit_err_q <= err_d;
         if (swap) begin
            fill_sel_q <= ~fill_sel_q;
         end
      end
   end

   // Next-state: commit/done/release handshake; late commits are rejected.
   always_comb begin
      state_d = state_q;
      swap    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (commit_i) begin
               state_d = VALID;
               swap    = 1'b1;
            end
         end
         VALID: begin
            err_d = commit_i;
            if (acc_done_i) begin
               state_d = RESULT;
            end
         end
         RESULT: begin
            err_d = commit_i;
            if (release_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cpu_data_o     = cpu_data_q;
   assign frame_valid_o  = (state_q == VALID);
   assign result_valid_o = (state_q == RESULT);
   assign commit_err_o   = commit_err_q;
   assign fill_sel_o     = fill_sel_q;

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Scoreboard bench for fft_pingpong_buffer.
// Reads push expectations; a negedge monitor pops and compares.
module tb_fft_pingpong_buffer;

   localparam int N  = 32;
   localparam int W  = 16;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_en, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_data_o;
   logic          commit, rel, acc_we, acc_done;
   logic [AW-1:0] acc_addr;
   logic [W-1:0]  acc_data;
   logic [W-1:0]  data_o_r [N];
   logic [W-1:0]  data_o_i [N];
   logic          frame_valid, result_valid, commit_err, fill_sel;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic        rd_flag;

   fft_pingpong_buffer #(.N_POINTS(N), .WORDWIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .cpu_en_i(cpu_en), .cpu_we_i(cpu_we),
      .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
      .cpu_data_o(cpu_data_o),
      .commit_i(commit), .release_i(rel),
      .acc_we_i(acc_we), .acc_addr_i(acc_addr),
      .acc_data_i(acc_data), .acc_done_i(acc_done),
      .data_o_r(data_o_r), .data_o_i(data_o_i),
      .frame_valid_o(frame_valid), .result_valid_o(result_valid),
      .commit_err_o(commit_err), .fill_sel_o(fill_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Track reads issued at each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) rd_flag <= 1'b0;
      else     rd_flag <= cpu_en && !cpu_we;
   end

   // Monitor: one cycle after a read, pop expected and compare.
   always @(negedge clk) begin
      if (rd_flag) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_underflow got %h want none", cpu_data_o);
         end else begin
            chk("cpu_rd", cpu_data_o, exp_q.pop_front());
         end
      end
   end

   task automatic rd(input logic [31:0] a, input logic [31:0] e);
      cpu_en   = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      cpu_en = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cpu_en    = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      @(negedge clk);
      cpu_en = 1'b0;
      cpu_we = 1'b0;
   endtask

   initial begin
      int nz;
      rst = 1'b1;
      cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      commit = 0; rel = 0; acc_we = 0; acc_done = 0;
      acc_addr = 0; acc_data = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_fill_sel", 32'(fill_sel), 0);
      chk("rst_frame", 32'(frame_valid), 0);
      chk("rst_result", 32'(result_valid), 0);
      chk("rst_err", 32'(commit_err), 0);
      chk("rst_cpu_data", cpu_data_o, 0);
      for (int k = 0; k < 2*N; k++) rd(32'(k), 0);
      for (int k = 0; k < 2*N; k++) rd(32'(2*N + k), 0);

      for (int k = 0; k < 2*N; k++) wr(32'(k), 32'(k));
      commit = 1; @(negedge clk); commit = 0;
      chk("commit_frame", 32'(frame_valid), 1);
      chk("commit_sel", 32'(fill_sel), 1);
      chk("view_r5", 32'(data_o_r[5]), 5);
      chk("view_i5", 32'(data_o_i[5]), 37);

      commit = 1; @(negedge clk); commit = 0;
      chk("rej_err_hi", 32'(commit_err), 1);
      chk("rej_sel", 32'(fill_sel), 1);
      @(negedge clk);
      chk("rej_err_lo", 32'(commit_err), 0);
      chk("rej_frame", 32'(frame_valid), 1);

      rel = 1; @(negedge clk); rel = 0;
      chk("rel_ign_frame", 32'(frame_valid), 1);
      chk("rel_ign_result", 32'(result_valid), 0);

      acc_we = 1; acc_addr = 3; acc_data = 16'h8001; acc_done = 1;
      @(negedge clk);
      acc_we = 0; acc_done = 0;
      chk("done_result", 32'(result_valid), 1);
      chk("done_frame", 32'(frame_valid), 0);
      chk("acc_r3", 32'(data_o_r[3]), 32'h8001);
      rd(32'(2*N + 3), 32'hFFFF_8001);
      rd(32'(2*N + 5), 5);
      rd(32'(2*N + 40), 40);
      rd(3, 0);

      acc_we = 1; acc_addr = 4; acc_data = 16'h7777;
      @(negedge clk);
      acc_we = 0;
      rd(32'(2*N + 4), 4);

      commit = 1; @(negedge clk); commit = 0;
      chk("rej2_err", 32'(commit_err), 1);
      chk("rej2_sel", 32'(fill_sel), 1);
      chk("rej2_result", 32'(result_valid), 1);

      rel = 1; @(negedge clk); rel = 0;
      chk("rel_result", 32'(result_valid), 0);
      chk("rel_frame", 32'(frame_valid), 0);

      cpu_en = 1; cpu_we = 1; cpu_addr = 10; cpu_wdata = 32'h1234;
      commit = 1;
      @(negedge clk);
      cpu_en = 0; cpu_we = 0; commit = 0;
      chk("wc_sel", 32'(fill_sel), 0);
      chk("wc_frame", 32'(frame_valid), 1);
      chk("wc_r10", 32'(data_o_r[10]), 32'h1234);
      chk("wc_r5", 32'(data_o_r[5]), 0);
      rd(10, 10);
      rd(3, 32'hFFFF_8001);
      rd(32'(2*N + 10), 32'h1234);

      wr(32'(2*N + 10), 32'hBEEF);
      chk("ro_r10", 32'(data_o_r[10]), 32'h1234);

      acc_done = 1; @(negedge clk); acc_done = 0;
      chk("done2_result", 32'(result_valid), 1);

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_result", 32'(result_valid), 0);
      chk("arst_frame", 32'(frame_valid), 0);
      chk("arst_sel", 32'(fill_sel), 0);
      chk("arst_cpu_data", cpu_data_o, 0);
      nz = 0;
      for (int k = 0; k < N; k++) begin
         if (data_o_r[k] != 0 || data_o_i[k] != 0) nz++;
      end
      chk("arst_view_nz", 32'(nz), 0);

      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("q_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
